// File: rtl/uart_rx_frame_if.sv
// Receiver-to-consumer bundle for uart_rx_frame: frame-complete strobe, data and status flags.
// The receiver drives through "master"; byte-consuming logic listens through "slave".
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_dv;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_break;
  logic                 rx_busy;

  modport master (
    output rx_dv, rx_byte, rx_parity_err, rx_frame_err, rx_break, rx_busy
  );

  modport slave (
    input rx_dv, rx_byte, rx_parity_err, rx_frame_err, rx_break, rx_busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 3-sample majority vote per bit, optional parity, 1/2 stop bits,
// reporting parity, framing and break conditions with a one-cycle rx_dv strobe.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 1181,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              osc_clk,
  input  logic              rst,
  input  logic              rx_serial,
  uart_rx_frame_if.master   rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID   = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] SAMP0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SAMP1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] SAMP2   = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD_PAR   = (PARITY == 2);
  localparam logic       HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_IDLE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   zeros_q, zeros_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   out_par_q, out_par_d;
  logic                   out_frame_q, out_frame_d;
  logic                   out_break_q, out_break_d;

  logic rx_s;
  logic maj;
  logic in_bit;
  logic sample_now;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign in_bit     = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
  assign sample_now = in_bit && (cnt_q == SAMP2);

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case can infer a latch.
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_serial};
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    zeros_d     = zeros_q;
    byte_d      = byte_q;
    out_par_d   = out_par_q;
    out_frame_d = out_frame_q;
    out_break_d = out_break_q;

    if (in_bit) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SAMP0) samp_d[0] = rx_s;
      if (cnt_q == SAMP1) samp_d[1] = rx_s;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (sample_now) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DATA;
            bit_cnt_d   = '0;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
            zeros_d     = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample_now) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          zeros_d = zeros_q & ~maj;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample_now) begin
          zeros_d   = zeros_q & ~maj;
          par_err_d = ((^shift_q) ^ maj) != ODD_PAR;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_now) begin
          zeros_d = zeros_q & ~maj;
          if (!maj) frame_err_d = 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            // Outputs load on the edge entering DONE so they change together with rx_dv.
            state_d     = S_DONE;
            byte_d      = shift_q;
            out_par_d   = HAS_PAR & par_err_q;
            out_frame_d = frame_err_d;
            out_break_d = zeros_d & frame_err_d;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        bit_cnt_d = '0;
        state_d   = frame_err_q ? S_WAIT_IDLE : S_IDLE;
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      // NOTE: synchroniser resets to 1 (idle line) so leaving reset never looks like a start edge.
      state_q     <= S_IDLE;
      sync_q      <= '1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      zeros_q     <= 1'b0;
      byte_q      <= '0;
      out_par_q   <= 1'b0;
      out_frame_q <= 1'b0;
      out_break_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      zeros_q     <= zeros_d;
      byte_q      <= byte_d;
      out_par_q   <= out_par_d;
      out_frame_q <= out_frame_d;
      out_break_q <= out_break_d;
    end
  end

  assign rx_if.rx_dv         = (state_q == S_DONE);
  assign rx_if.rx_byte       = byte_q;
  assign rx_if.rx_parity_err = out_par_q;
  assign rx_if.rx_frame_err  = out_frame_q;
  assign rx_if.rx_break      = out_break_q;
  assign rx_if.rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three instances (8N1, 7E1, 8O2) at 16 clocks per bit,
// each scenario a task with inline expected-value comparisons.
module tb_uart_rx_frame;

  localparam int CPB = 16;
  localparam int MID = 7;

  logic osc_clk = 1'b0;
  logic rst     = 1'b1;
  logic line_a  = 1'b1;
  logic line_b  = 1'b1;
  logic line_c  = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 osc_clk = ~osc_clk;
  always @(posedge osc_clk) cyc++;

  uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_rx_frame_if #(.DATA_BITS(7)) if_b ();
  uart_rx_frame_if #(.DATA_BITS(8)) if_c ();

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2))
    dut_a (.osc_clk(osc_clk), .rst(rst), .rx_serial(line_a), .rx_if(if_a));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2))
    dut_b (.osc_clk(osc_clk), .rst(rst), .rx_serial(line_b), .rx_if(if_b));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2))
    dut_c (.osc_clk(osc_clk), .rst(rst), .rx_serial(line_c), .rx_if(if_c));

  // Pulse monitors: count every cycle rx_dv is high, log 8O2 results in order.
  int         dv_a = 0, dv_b = 0, dv_c = 0, dv_cyc_a = 0;
  logic [7:0] log_c_byte [0:7];
  logic       log_c_perr [0:7];

  always @(negedge osc_clk) begin
    if (if_a.rx_dv === 1'b1) begin
      dv_a++;
      dv_cyc_a = cyc;
    end
    if (if_b.rx_dv === 1'b1) dv_b++;
    if (if_c.rx_dv === 1'b1) begin
      log_c_byte[dv_c % 8] = if_c.rx_byte;
      log_c_perr[dv_c % 8] = if_c.rx_parity_err;
      dv_c++;
    end
  end

  task automatic set_line(input int which, input logic b);
    case (which)
      0:       line_a = b;
      1:       line_b = b;
      default: line_c = b;
    endcase
  endtask

  task automatic drive_bit(input int which, input logic b, input int n);
    set_line(which, b);
    repeat (n) @(negedge osc_clk);
  endtask

  // Sends one frame; spike_bit >= 0 inverts that frame bit for one cycle at its centre sample.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int par, input logic par_flip, input logic stop_val,
                            input int nstop, input int spike_bit, output int t0);
    logic [11:0] bits;
    logic        p;
    int          n;
    t0 = cyc;
    p  = 1'b0;
    for (int i = 0; i < nbits; i++) p ^= data[i];
    if (par == 2) p = ~p;
    p ^= par_flip;
    n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[n++] = data[i];
    if (par != 0) bits[n++] = p;
    for (int i = 0; i < nstop; i++) bits[n++] = stop_val;
    for (int k = 0; k < n; k++) begin
      if (k == spike_bit) begin
        drive_bit(which, bits[k], MID + 1);
        drive_bit(which, ~bits[k], 1);
        drive_bit(which, bits[k], CPB - MID - 2);
      end else begin
        drive_bit(which, bits[k], CPB);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge osc_clk);
    checks++; if (if_a.rx_dv !== 1'b0 || if_a.rx_busy !== 1'b0) begin errors++;
      $display("FAIL reset_a_ctl: dv=%b busy=%b expected 0 0", if_a.rx_dv, if_a.rx_busy); end
    checks++; if (if_a.rx_byte !== 8'h00 || if_a.rx_parity_err !== 1'b0 ||
                  if_a.rx_frame_err !== 1'b0 || if_a.rx_break !== 1'b0) begin errors++;
      $display("FAIL reset_a_data: byte=%h p=%b f=%b b=%b expected 00 0 0 0", if_a.rx_byte,
               if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_break); end
    checks++; if (if_b.rx_byte !== 7'h00 || if_b.rx_busy !== 1'b0 || if_b.rx_dv !== 1'b0) begin errors++;
      $display("FAIL reset_b: byte=%h busy=%b dv=%b expected 00 0 0", if_b.rx_byte, if_b.rx_busy, if_b.rx_dv); end
    checks++; if (if_c.rx_byte !== 8'h00 || if_c.rx_busy !== 1'b0 || if_c.rx_parity_err !== 1'b0) begin errors++;
      $display("FAIL reset_c: byte=%h busy=%b p=%b expected 00 0 0", if_c.rx_byte, if_c.rx_busy, if_c.rx_parity_err); end
    rst = 1'b0;
    repeat (4) @(negedge osc_clk);
  endtask

  task automatic test_basic_8n1();
    int t0, d0;
    d0 = dv_a;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1, -1, t0);
    drive_bit(0, 1'b1, 2 * CPB);
    checks++; if (dv_a - d0 !== 1) begin errors++;
      $display("FAIL basic_pulses: got %0d expected 1", dv_a - d0); end
    checks++; if (dv_cyc_a !== t0 + 2 + 9 * CPB + MID + 3) begin errors++;
      $display("FAIL basic_latency: dv cycle %0d expected %0d", dv_cyc_a, t0 + 2 + 9 * CPB + MID + 3); end
    checks++; if (if_a.rx_byte !== 8'hA5) begin errors++;
      $display("FAIL basic_byte: got %h expected a5", if_a.rx_byte); end
    checks++; if ({if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_break, if_a.rx_busy} !== 4'b0000) begin errors++;
      $display("FAIL basic_flags: p/f/b/busy=%b expected 0000",
               {if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_break, if_a.rx_busy}); end
  endtask

  task automatic test_parity_7e1();
    int t0, d0;
    d0 = dv_b;
    send_frame(1, 9'h041, 7, 1, 1'b0, 1'b1, 1, -1, t0);
    drive_bit(1, 1'b1, 2 * CPB);
    checks++; if (dv_b - d0 !== 1 || if_b.rx_byte !== 7'h41 || if_b.rx_parity_err !== 1'b0) begin errors++;
      $display("FAIL parity_good: pulses=%0d byte=%h perr=%b expected 1 41 0", dv_b - d0, if_b.rx_byte, if_b.rx_parity_err); end
    send_frame(1, 9'h041, 7, 1, 1'b1, 1'b1, 1, -1, t0);
    drive_bit(1, 1'b1, 2 * CPB);
    checks++; if (dv_b - d0 !== 2 || if_b.rx_byte !== 7'h41 || if_b.rx_parity_err !== 1'b1) begin errors++;
      $display("FAIL parity_bad: pulses=%0d byte=%h perr=%b expected 2 41 1", dv_b - d0, if_b.rx_byte, if_b.rx_parity_err); end
    checks++; if (if_b.rx_frame_err !== 1'b0) begin errors++;
      $display("FAIL parity_bad_ferr: got %b expected 0", if_b.rx_frame_err); end
  endtask

  task automatic test_noise();
    int t0, d0;
    logic busy_seen;
    d0 = dv_a;
    busy_seen = 1'b0;
    set_line(0, 1'b0);
    repeat (3) @(negedge osc_clk);
    set_line(0, 1'b1);
    repeat (2) begin
      @(negedge osc_clk);
      busy_seen |= if_a.rx_busy;
    end
    repeat (2 * CPB) @(negedge osc_clk);
    checks++; if (busy_seen !== 1'b1) begin errors++;
      $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen); end
    checks++; if (dv_a !== d0 || if_a.rx_busy !== 1'b0) begin errors++;
      $display("FAIL glitch_reject: pulses=%0d busy=%b expected 0 0", dv_a - d0, if_a.rx_busy); end
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 1, 4, t0);
    drive_bit(0, 1'b1, 2 * CPB);
    checks++; if (dv_a - d0 !== 1 || if_a.rx_byte !== 8'h5A) begin errors++;
      $display("FAIL spike_reject: pulses=%0d byte=%h expected 1 5a", dv_a - d0, if_a.rx_byte); end
  endtask

  task automatic test_frame_err_break();
    int t0, d0;
    d0 = dv_a;
    send_frame(0, 9'h055, 8, 0, 1'b0, 1'b0, 1, -1, t0);
    checks++; if (dv_a - d0 !== 1 || if_a.rx_byte !== 8'h55 || if_a.rx_frame_err !== 1'b1 || if_a.rx_break !== 1'b0) begin errors++;
      $display("FAIL frame_err: pulses=%0d byte=%h f=%b b=%b expected 1 55 1 0", dv_a - d0,
               if_a.rx_byte, if_a.rx_frame_err, if_a.rx_break); end
    drive_bit(0, 1'b1, 3 * CPB);
    d0 = dv_a;
    drive_bit(0, 1'b0, 30 * CPB);
    checks++; if (dv_a - d0 !== 1) begin errors++;
      $display("FAIL break_pulses: got %0d expected 1", dv_a - d0); end
    checks++; if (if_a.rx_break !== 1'b1 || if_a.rx_frame_err !== 1'b1 || if_a.rx_byte !== 8'h00) begin errors++;
      $display("FAIL break_flags: b=%b f=%b byte=%h expected 1 1 00", if_a.rx_break, if_a.rx_frame_err, if_a.rx_byte); end
    drive_bit(0, 1'b1, 3 * CPB);
    checks++; if (dv_a - d0 !== 1 || if_a.rx_busy !== 1'b0) begin errors++;
      $display("FAIL break_release: pulses=%0d busy=%b expected 1 0", dv_a - d0, if_a.rx_busy); end
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1, 1, -1, t0);
    drive_bit(0, 1'b1, 2 * CPB);
    checks++; if (dv_a - d0 !== 2 || if_a.rx_byte !== 8'h3C || if_a.rx_frame_err !== 1'b0 || if_a.rx_break !== 1'b0) begin errors++;
      $display("FAIL after_break: pulses=%0d byte=%h f=%b b=%b expected 2 3c 0 0", dv_a - d0,
               if_a.rx_byte, if_a.rx_frame_err, if_a.rx_break); end
  endtask

  task automatic test_back_to_back();
    int t0, d0;
    logic [7:0] exp_bytes [0:2];
    exp_bytes[0] = 8'h00;
    exp_bytes[1] = 8'hFF;
    exp_bytes[2] = 8'h80;
    d0 = dv_c;
    for (int i = 0; i < 3; i++) send_frame(2, {1'b0, exp_bytes[i]}, 8, 2, 1'b0, 1'b1, 2, -1, t0);
    drive_bit(2, 1'b1, 2 * CPB);
    checks++; if (dv_c - d0 !== 3) begin errors++;
      $display("FAIL b2b_pulses: got %0d expected 3", dv_c - d0); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (log_c_byte[(d0 + i) % 8] !== exp_bytes[i] || log_c_perr[(d0 + i) % 8] !== 1'b0) begin errors++;
        $display("FAIL b2b_frame%0d: byte=%h perr=%b expected %h 0", i, log_c_byte[(d0 + i) % 8],
                 log_c_perr[(d0 + i) % 8], exp_bytes[i]); end
    end
    checks++; if (if_c.rx_frame_err !== 1'b0 || if_c.rx_busy !== 1'b0) begin errors++;
      $display("FAIL b2b_final: f=%b busy=%b expected 0 0", if_c.rx_frame_err, if_c.rx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int t0, d0;
    logic [7:0] v;
    v  = 8'h96;
    d0 = dv_a;
    drive_bit(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(0, v[i], CPB);
    drive_bit(0, v[4], 8);
    checks++; if (if_a.rx_busy !== 1'b1) begin errors++;
      $display("FAIL mid_busy: got %b expected 1", if_a.rx_busy); end
    rst = 1'b1;
    set_line(0, 1'b1);
    @(negedge osc_clk);
    checks++; if ({if_a.rx_dv, if_a.rx_busy, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_break} !== 5'b0 ||
                  if_a.rx_byte !== 8'h00) begin errors++;
      $display("FAIL mid_reset_a: dv/busy/p/f/b=%b byte=%h expected 00000 00",
               {if_a.rx_dv, if_a.rx_busy, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_break}, if_a.rx_byte); end
    checks++; if (if_b.rx_byte !== 7'h00 || if_b.rx_parity_err !== 1'b0) begin errors++;
      $display("FAIL mid_reset_b: byte=%h perr=%b expected 00 0", if_b.rx_byte, if_b.rx_parity_err); end
    rst = 1'b0;
    drive_bit(0, 1'b1, 3 * CPB);
    checks++; if (dv_a !== d0) begin errors++;
      $display("FAIL mid_no_dv: pulses=%0d expected 0", dv_a - d0); end
    send_frame(0, 9'h096, 8, 0, 1'b0, 1'b1, 1, -1, t0);
    drive_bit(0, 1'b1, 2 * CPB);
    checks++; if (dv_a - d0 !== 1 || if_a.rx_byte !== 8'h96 || if_a.rx_frame_err !== 1'b0) begin errors++;
      $display("FAIL mid_next_frame: pulses=%0d byte=%h f=%b expected 1 96 0", dv_a - d0,
               if_a.rx_byte, if_a.rx_frame_err); end
  endtask

  initial begin
    @(negedge osc_clk);
    test_reset();
    test_basic_8n1();
    test_parity_7e1();
    test_noise();
    test_frame_err_break();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
